// File: rtl/mig_tt_eval_if.sv
// Handshake bundle for the MIG truth-table evaluator: the program-load stream
// in one direction and the truth-table result stream in the other.
interface mig_tt_eval_if #(
    parameter int OP_W = 6
);
    logic                  prog_valid;
    logic                  prog_ready;
    logic [3*(OP_W+1)-1:0] prog_node;
    logic                  prog_last;
    logic [OP_W-1:0]       root_sel;
    logic                  root_inv;
    logic                  tt_valid;
    logic                  tt_ready;
    logic [15:0]           tt_data;
    logic                  tt_err;

    modport master (
        output prog_valid, prog_node, prog_last, root_sel, root_inv, tt_ready,
        input  prog_ready, tt_valid, tt_data, tt_err
    );

    modport slave (
        input  prog_valid, prog_node, prog_last, root_sel, root_inv, tt_ready,
        output prog_ready, tt_valid, tt_data, tt_err
    );
endinterface

// File: rtl/mig_tt_eval.sv
// Bit-parallel evaluator for 4-input majority-inverter graphs: loads one node
// per beat, evaluates one node per cycle, returns the 16-bit truth table of the root.
module mig_tt_eval #(
    parameter int MAX_NODES = 16,
    parameter int OP_W      = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    mig_tt_eval_if.slave bus
);
    localparam int NODE_W = 3 * (OP_W + 1);
    localparam int CNT_W  = $clog2(MAX_NODES + 1);
    localparam int IDX_W  = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;

    typedef enum logic [1:0] {S_LOAD, S_EVAL, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  k_q, k_d;
    logic [OP_W-1:0]   root_sel_q, root_sel_d;
    logic              root_inv_q, root_inv_d;
    logic              err_q, err_d;
    logic              tt_valid_q, tt_valid_d;
    logic [15:0]       tt_data_q, tt_data_d;
    logic [1:0]        rst_sync_q;

    logic [NODE_W-1:0] prog_mem [MAX_NODES];
    logic [15:0]       node_mem [MAX_NODES];

    logic              prog_ready;
    logic              prog_hs;
    logic              prog_we;
    logic              node_we;
    logic [IDX_W-1:0]  k_idx;
    logic [NODE_W-1:0] cur_node;
    logic [15:0]       fan [3];
    logic              fanin_err;
    logic [15:0]       maj_val;
    logic [15:0]       root_word;
    logic              root_ok;

    // Leaf operands 0..4: constant 0 and the four input variable patterns.
    function automatic logic [15:0] leaf_word(input logic [2:0] sel);
        case (sel)
            3'd1:    return 16'hAAAA;
            3'd2:    return 16'hCCCC;
            3'd3:    return 16'hF0F0;
            3'd4:    return 16'hFF00;
            default: return 16'h0000;
        endcase
    endfunction

    // Reset asserts asynchronously but the LOAD stream only opens two clean edges later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign prog_ready = (state_q == S_LOAD) && rst_sync_q[1];
    assign prog_hs    = bus.prog_valid && prog_ready;
    assign k_idx      = IDX_W'(k_q);

    // NOTE: storage arrays carry no reset; every word is written before it is read.
    always_ff @(posedge clk) begin
        if (prog_we) prog_mem[IDX_W'(count_q)] <= bus.prog_node;
        if (node_we) node_mem[k_idx]           <= maj_val;
    end

    always_comb begin
        logic [OP_W-1:0] fan_op;
        logic [15:0]     fan_word;
        cur_node  = prog_mem[k_idx];
        fanin_err = 1'b0;
        fan       = '{default: 16'h0000};
        for (int f = 0; f < 3; f++) begin
            fan_op   = cur_node[f*(OP_W+1) +: OP_W];
            fan_word = 16'h0000;
            if (fan_op < OP_W'(5))
                fan_word = leaf_word(fan_op[2:0]);
            else if (int'(fan_op) >= int'(k_q) + 5)
                fanin_err = 1'b1;
            else
                fan_word = node_mem[IDX_W'(fan_op - OP_W'(5))];
            fan[f] = fan_word ^ {16{cur_node[f*(OP_W+1)+OP_W]}};
        end
        maj_val = (fan[0] & fan[1]) | (fan[0] & fan[2]) | (fan[1] & fan[2]);

        // The root may be the node being evaluated right now, so bypass the memory.
        root_ok   = int'(root_sel_q) < int'(count_q) + 5;
        root_word = 16'h0000;
        if (root_sel_q < OP_W'(5))
            root_word = leaf_word(root_sel_q[2:0]);
        else if (int'(root_sel_q) == int'(k_q) + 5)
            root_word = maj_val;
        else
            root_word = node_mem[IDX_W'(root_sel_q - OP_W'(5))];
    end

    // NOTE: every next-state signal gets its hold value first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        k_d        = k_q;
        root_sel_d = root_sel_q;
        root_inv_d = root_inv_q;
        err_d      = err_q;
        tt_valid_d = tt_valid_q;
        tt_data_d  = tt_data_q;
        prog_we    = 1'b0;
        node_we    = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (prog_hs) begin
                    prog_we = 1'b1;
                    count_d = count_q + CNT_W'(1);
                    if (bus.prog_last) begin
                        state_d    = S_EVAL;
                        k_d        = '0;
                        root_sel_d = bus.root_sel;
                        root_inv_d = bus.root_inv;
                    end else if (count_q == CNT_W'(MAX_NODES - 1)) begin
                        state_d    = S_EVAL;
                        k_d        = '0;
                        root_sel_d = OP_W'(MAX_NODES + 4);
                        root_inv_d = 1'b0;
                        err_d      = 1'b1;
                    end
                end
            end
            S_EVAL: begin
                node_we = 1'b1;
                k_d     = k_q + CNT_W'(1);
                if (fanin_err) err_d = 1'b1;
                if (k_q == count_q - CNT_W'(1)) begin
                    state_d    = S_DONE;
                    tt_valid_d = 1'b1;
                    if (root_ok) begin
                        tt_data_d = root_word ^ {16{root_inv_q}};
                    end else begin
                        tt_data_d = 16'h0000;
                        err_d     = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (bus.tt_ready) begin
                    state_d    = S_LOAD;
                    tt_valid_d = 1'b0;
                    err_d      = 1'b0;
                    count_d    = '0;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_LOAD;
            count_q    <= '0;
            k_q        <= '0;
            root_sel_q <= '0;
            root_inv_q <= 1'b0;
            err_q      <= 1'b0;
            tt_valid_q <= 1'b0;
            tt_data_q  <= 16'h0000;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            k_q        <= k_d;
            root_sel_q <= root_sel_d;
            root_inv_q <= root_inv_d;
            err_q      <= err_d;
            tt_valid_q <= tt_valid_d;
            tt_data_q  <= tt_data_d;
        end
    end

    assign bus.prog_ready = prog_ready;
    assign bus.tt_valid   = tt_valid_q;
    assign bus.tt_data    = tt_data_q;
    assign bus.tt_err     = err_q;
endmodule

// File: doc/mig_tt_eval.md
Name: mig_tt_eval

Overview:
- Bit-parallel evaluator for 4-input majority-inverter graph (MIG) netlists: loads a MIG program one node per beat, then computes the 16-bit truth table of the selected root.
- This is the inverse direction to exact synthesis (truth table -> MIG): it takes a MIG and returns its truth table.
- Sits beside the netlist library as an on-chip equivalence checker: its result is compared against the target NPN-class truth table.

Parameters:
- MAX_NODES, 16, maximum majority nodes per program (1..59)
- OP_W, 6, operand index width; must satisfy 2^OP_W >= MAX_NODES+5

Ports:
- clk  input  1  clock, all state rising-edge
- rst_n  input  1  asynchronous active-low reset
- prog_valid  input  1  program beat valid
- prog_ready  output  1  evaluator accepts a beat
- prog_node  input  3*(OP_W+1)  node word {c2,op2,c1,op1,c0,op0}; cK = complement fanin K
- prog_last  input  1  final node of program
- root_sel  input  OP_W  root operand index, sampled on the last beat
- root_inv  input  1  complement root, sampled on the last beat
- tt_valid  output  1  result valid
- tt_ready  input  1  consumer accepts result
- tt_data  output  16  truth table; bit i = f(x0=i[0], x1=i[1], x2=i[2], x3=i[3])
- tt_err  output  1  program error flag, qualified by tt_valid

Behaviour:
- Operand encoding:
  - 0 = constant 0
  - 1..4 = x0..x3, with words 0xAAAA, 0xCCCC, 0xF0F0, 0xFF00
  - 5+k = node k
- Node value = bitwise MAJ(a,b,c) = (a&b)|(a&c)|(b&c), where each fanin is XORed with 0xFFFF when its c bit is set.
- Storage: node memory of MAX_NODES x 16-bit words, plus a program buffer of MAX_NODES node words.
- Reset (async assert, sync deassert internally): state=LOAD, node count=0, prog_ready=0 during reset then 1 in LOAD, tt_valid=0, tt_data=0, tt_err=0.
- FSM: LOAD -> EVAL -> DONE -> LOAD.
- LOAD:
  - prog_ready=1.
  - Each handshake (prog_valid & prog_ready) stores prog_node at index count and increments count.
  - A beat with prog_last=1 captures root_sel/root_inv and moves to EVAL.
  - A beat accepted at count==MAX_NODES-1 with prog_last=0 sets err, is treated as last, and root defaults to the last node.
- EVAL:
  - prog_ready=0.
  - Evaluates node k in cycle k (k = 0..N-1); exactly one node per cycle.
  - A fanin index >= 5+k (forward or self reference) or > MAX_NODES+4 sets err and reads as 0x0000.
- Transition to DONE after node N-1; this cycle registers the root word XOR {16{root_inv}} into tt_data.
  - Root index invalid (>= 5+N) sets err; tt_data is then 0.
- Latency: tt_valid rises N+1 cycles after the last-beat handshake.
- DONE:
  - tt_valid=1; tt_data and tt_err held stable until tt_ready.
  - On handshake: tt_valid=0, err and count clear, return to LOAD.
  - prog_ready=0 throughout, so no overlap between programs.
- tt_ready asserted before tt_valid has no effect.
- Reset mid-LOAD or mid-EVAL: the program is discarded and no result is produced.

Test Plan:
- One node {op0=1,op1=2,op2=3, no complements}, last, root_sel=5, root_inv=0 -> tt_data=0xE8E8, tt_err=0, tt_valid 2 cycles after the beat.
- One node MAJ(x0,x3,const0) with root_sel=5 -> 0xAA00. One node MAJ(x1,x2,~const0) -> 0xFCFC.
- Two nodes, node0=MAJ(x1,x2,~0), node1=MAJ(x0,x3,node0), root_sel=6, root_inv=1 -> 0x0157 (uninverted 0xFEA8).
- Forward reference: node0 fanin op2=6 -> tt_err=1; a root_sel=2 program with valid nodes -> 0xCCCC, err=0.
- Backpressure: hold tt_ready=0 for 10 cycles -> tt_data stable, prog_ready=0; on release, LOAD resumes the next cycle. Feed MAX_NODES beats with no prog_last -> err=1.
- Drop rst_n during EVAL of a 10-node program -> tt_valid=0, count=0; the next program evaluates correctly.
